// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master to one-slave Wishbone arbiter in front of the
// on-chip RAM slave. Round-robin on ties, grant held for the whole cyc,
// and a watchdog that aborts the slave and returns err when no ack arrives.
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    // master 0 (CPU data port)
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,
    // master 1 (debug / DMA)
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,
    // slave side
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    // A zero timeout disables the watchdog entirely.
    localparam logic                 WDOG_EN   = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [CNT_WIDTH-1:0] WDOG_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [CNT_WIDTH-1:0] WDOG_ONE  = CNT_WIDTH'(1'b1);
    localparam logic [CNT_WIDTH-1:0] WDOG_ZERO = CNT_WIDTH'(1'b0);

    state_t               state_r;
    state_t               state_s;
    logic                 grant_r;        // 0 = master 0, 1 = master 1
    logic                 grant_s;
    logic                 last_grant_r;   // master served most recently
    logic                 last_grant_s;
    logic [CNT_WIDTH-1:0] wdog_r;
    logic [CNT_WIDTH-1:0] wdog_s;
    logic                 err_r;          // one-cycle error pulse to the granted master
    logic                 err_s;
    logic                 err_sent_r;     // pulse for this ERR episode already issued
    logic                 err_sent_s;

    logic                 req0_s;
    logic                 req1_s;
    logic                 g_cyc_s;
    logic                 g_stb_s;
    logic                 g_we_s;
    logic [31:0]          g_adr_s;
    logic [31:0]          g_dat_s;
    logic [3:0]           g_sel_s;

    assign req0_s = m0_cyc_i & m0_stb_i;
    assign req1_s = m1_cyc_i & m1_stb_i;

    // Route the granted master's request lines onto a common set of signals.
    always_comb begin
        g_cyc_s = 1'b0;
        g_stb_s = 1'b0;
        g_we_s  = 1'b0;
        g_adr_s = 32'h0000_0000;
        g_dat_s = 32'h0000_0000;
        g_sel_s = 4'h0;
        if (grant_r) begin
            g_cyc_s = m1_cyc_i;
            g_stb_s = m1_stb_i;
            g_we_s  = m1_we_i;
            g_adr_s = m1_adr_i;
            g_dat_s = m1_dat_i;
            g_sel_s = m1_sel_i;
        end else begin
            g_cyc_s = m0_cyc_i;
            g_stb_s = m0_stb_i;
            g_we_s  = m0_we_i;
            g_adr_s = m0_adr_i;
            g_dat_s = m0_dat_i;
            g_sel_s = m0_sel_i;
        end
    end

    // Next-state logic: arbitration, cyc lock, release and watchdog.
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        wdog_s       = wdog_r;
        case (state_r)
            IDLE: begin
                wdog_s = WDOG_ZERO;
                if (req0_s && req1_s) begin
                    // Tie: the master not served last time wins.
                    grant_s = ~last_grant_r;
                    state_s = BUSY;
                end else if (req0_s) begin
                    grant_s = 1'b0;
                    state_s = BUSY;
                end else if (req1_s) begin
                    grant_s = 1'b1;
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (!g_cyc_s) begin
                    // Granted master ended its cycle: hand back the bus.
                    last_grant_s = grant_r;
                    state_s      = IDLE;
                    wdog_s       = WDOG_ZERO;
                end else if (g_stb_s && !s_ack_i) begin
                    if (WDOG_EN && (wdog_r == WDOG_LAST)) begin
                        state_s = ERR;
                        wdog_s  = WDOG_ZERO;
                    end else if (WDOG_EN) begin
                        wdog_s = wdog_r + WDOG_ONE;
                    end else begin
                        wdog_s = WDOG_ZERO;
                    end
                end else begin
                    // An ack (which beats a simultaneous timeout) or an idle
                    // stb restarts the watchdog.
                    wdog_s = WDOG_ZERO;
                end
            end
            ERR: begin
                wdog_s = WDOG_ZERO;
                if (!g_cyc_s) begin
                    last_grant_s = grant_r;
                    state_s      = IDLE;
                end else begin
                    state_s = ERR;
                end
            end
            default: begin
                state_s      = IDLE;
                grant_s      = 1'b0;
                last_grant_s = 1'b1;
                wdog_s       = WDOG_ZERO;
            end
        endcase
    end

    // Error pulse: raised once, on the cycle after the first ERR cycle.
    always_comb begin
        err_s      = 1'b0;
        err_sent_s = 1'b0;
        if (state_r == ERR) begin
            err_s      = ~err_sent_r;
            err_sent_s = 1'b1;
        end else begin
            err_s      = 1'b0;
            err_sent_s = 1'b0;
        end
    end

    // State, grant, watchdog and error registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r      <= IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            wdog_r       <= WDOG_ZERO;
            err_r        <= 1'b0;
            err_sent_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            wdog_r       <= wdog_s;
            err_r        <= err_s;
            err_sent_r   <= err_sent_s;
        end
    end

    // Outputs: slave mirrors the granted master only while BUSY; acks and
    // read data only flow back while BUSY, so late acks in ERR are dropped.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = 32'h0000_0000;
        s_dat_o  = 32'h0000_0000;
        s_sel_o  = 4'h0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_dat_o = 32'h0000_0000;
        m1_dat_o = 32'h0000_0000;
        if (state_r == BUSY) begin
            s_cyc_o  = g_cyc_s;
            s_stb_o  = g_stb_s;
            s_we_o   = g_we_s;
            s_adr_o  = g_adr_s;
            s_dat_o  = g_dat_s;
            s_sel_o  = g_sel_s;
            m0_ack_o = s_ack_i & ~grant_r;
            m1_ack_o = s_ack_i & grant_r;
            m0_dat_o = s_dat_i;
            m1_dat_o = s_dat_i;
        end else begin
            s_cyc_o  = 1'b0;
            s_stb_o  = 1'b0;
        end
        m0_err_o = err_r & ~grant_r;
        m1_err_o = err_r & grant_r;
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: scripted per-cycle vector table,
// hand-written reset/write/read sequences, then random traffic from both
// masters against a memory scoreboard.
module tb_wb_arbiter2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        mcyc  [2];
    logic        mstb  [2];
    logic        mwe   [2];
    logic [31:0] madr  [2];
    logic [31:0] mwdat [2];
    logic [3:0]  msel  [2];

    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdat, m1_rdat;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_wdat;
    logic [3:0]  s_sel;
    logic        s_ack;
    logic [31:0] s_rdat;

    // Bench-side slave
    logic        slave_en;
    logic        rand_lat;
    logic        tb_ack;
    logic        sl_ack;
    int          sl_cnt;
    int          sl_lat;
    logic [31:0] sl_rdata;
    logic [31:0] sl_mem [16];

    logic [31:0] ref_mem [16];
    int          vectors;
    int          miscompares;
    int          done_cnt;

    assign s_ack  = slave_en ? sl_ack : tb_ack;
    assign s_rdat = sl_ack ? sl_rdata : 32'h0;

    wb_arbiter2 #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut (
        .wb_clk_i (clk),      .wb_rst_ni(rst_n),
        .m0_cyc_i (mcyc[0]),  .m0_stb_i (mstb[0]),  .m0_we_i (mwe[0]),
        .m0_adr_i (madr[0]),  .m0_dat_i (mwdat[0]), .m0_sel_i(msel[0]),
        .m0_ack_o (m0_ack),   .m0_err_o (m0_err),   .m0_dat_o(m0_rdat),
        .m1_cyc_i (mcyc[1]),  .m1_stb_i (mstb[1]),  .m1_we_i (mwe[1]),
        .m1_adr_i (madr[1]),  .m1_dat_i (mwdat[1]), .m1_sel_i(msel[1]),
        .m1_ack_o (m1_ack),   .m1_err_o (m1_err),   .m1_dat_o(m1_rdat),
        .s_cyc_o  (s_cyc),    .s_stb_o  (s_stb),    .s_we_o  (s_we),
        .s_adr_o  (s_adr),    .s_dat_o  (s_wdat),   .s_sel_o (s_sel),
        .s_ack_i  (s_ack),    .s_dat_i  (s_rdat)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // RAM slave: acks sl_lat cycles after seeing stb, one-cycle ack pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sl_ack   <= 1'b0;
            sl_cnt   <= 0;
            sl_lat   <= 0;
            sl_rdata <= 32'h0;
            for (int i = 0; i < 16; i++) sl_mem[i] <= 32'h0;
        end else if (sl_ack) begin
            sl_ack <= 1'b0;
            sl_cnt <= 0;
        end else if (slave_en && s_cyc && s_stb) begin
            if (sl_cnt >= sl_lat) begin
                sl_ack   <= 1'b1;
                sl_cnt   <= 0;
                sl_lat   <= rand_lat ? int'($urandom_range(2, 0)) : 0;
                sl_rdata <= sl_mem[s_adr[5:2]];
                if (s_we) sl_mem[s_adr[5:2]] <= merge(sl_mem[s_adr[5:2]], s_wdat, s_sel);
            end else begin
                sl_cnt <= sl_cnt + 1;
            end
        end else begin
            sl_cnt <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic ack_of(input int id);
        return (id == 1) ? m1_ack : m0_ack;
    endfunction

    function automatic logic [31:0] rdat_of(input int id);
        return (id == 1) ? m1_rdat : m0_rdat;
    endfunction

    // One beat: called at a negedge, returns at the negedge after the ack.
    task automatic beat(input int id, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        output logic [31:0] rd, output logic got);
        mcyc[id] = 1'b1; mstb[id] = 1'b1; mwe[id] = we;
        madr[id] = adr;  mwdat[id] = dat; msel[id] = sel;
        got = 1'b0;
        rd  = 32'h0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk); #1;
            if (ack_of(id)) begin
                got = 1'b1;
                rd  = rdat_of(id);
            end
        end
        @(negedge clk);
    endtask

    // Random master: bursts of 1..3 beats under one cyc, random gaps.
    task automatic master_run(input int id, input int n);
        logic [31:0] rd;
        logic        got;
        logic        we;
        logic [3:0]  a;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          nb;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(3, 0)) @(negedge clk);
            nb = int'($urandom_range(3, 1));
            for (int b = 0; b < nb; b++) begin
                we  = 1'($urandom_range(1, 0));
                a   = 4'($urandom_range(15, 0));
                dat = $urandom;
                sel = 4'($urandom_range(15, 1));
                beat(id, we, {26'h0, a, 2'b00}, dat, sel, rd, got);
                chk((id == 1) ? "m1_beat_ack" : "m0_beat_ack", {31'h0, got}, 32'h1);
                if (got && we) ref_mem[a] = merge(ref_mem[a], dat, sel);
                else if (got) chk("read_data", rd, ref_mem[a]);
                else ref_mem[a] = ref_mem[a];
                if ($urandom_range(3, 0) == 0 && b < nb - 1) begin
                    mstb[id] = 1'b0;
                    @(negedge clk);
                end
            end
            mcyc[id] = 1'b0; mstb[id] = 1'b0; mwe[id] = 1'b0;
            @(negedge clk);
        end
        done_cnt++;
    endtask

    typedef struct packed {
        logic [4:0] stim;   // {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack}
        logic       ecyc;   // expected s_cyc_o / s_stb_o
        logic [1:0] eadr;   // 0: 0, 1: 0x100, 2: 0x200
        logic [3:0] eflg;   // {m0_ack, m1_ack, m0_err, m1_err}
    } vec_t;

    vec_t        tbl [24];
    logic [31:0] exp_adr;
    logic [31:0] rd;
    logic        got;

    initial begin #500000; $display("FAIL global_timeout: bench did not finish"); $fatal(1); end

    initial begin
        vectors = 0; miscompares = 0; done_cnt = 0;
        tb_ack = 1'b0; slave_en = 1'b0; rand_lat = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mcyc[i] = 1'b0; mstb[i] = 1'b0; mwe[i] = 1'b0;
            mwdat[i] = 32'h0; msel[i] = 4'hF;
        end
        madr[0] = 32'h100; madr[1] = 32'h200;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

        // tie -> m0, both withdraw, tie -> m1, m0 lock with m1 waiting,
        // m1 timeout with late acks, tie after error -> m0
        tbl[0]  = '{5'b11110, 1'b0, 2'd0, 4'b0000};
        tbl[1]  = '{5'b11111, 1'b1, 2'd1, 4'b1000};
        tbl[2]  = '{5'b00000, 1'b0, 2'd1, 4'b0000};
        tbl[3]  = '{5'b11110, 1'b0, 2'd0, 4'b0000};
        tbl[4]  = '{5'b11111, 1'b1, 2'd2, 4'b0100};
        tbl[5]  = '{5'b11000, 1'b0, 2'd2, 4'b0000};
        tbl[6]  = '{5'b11000, 1'b0, 2'd0, 4'b0000};
        tbl[7]  = '{5'b11111, 1'b1, 2'd1, 4'b1000};
        tbl[8]  = '{5'b11110, 1'b1, 2'd1, 4'b0000};
        tbl[9]  = '{5'b11111, 1'b1, 2'd1, 4'b1000};
        tbl[10] = '{5'b11111, 1'b1, 2'd1, 4'b1000};
        tbl[11] = '{5'b00110, 1'b0, 2'd1, 4'b0000};
        tbl[12] = '{5'b00110, 1'b0, 2'd0, 4'b0000};
        tbl[13] = '{5'b00110, 1'b1, 2'd2, 4'b0000};
        tbl[14] = '{5'b00110, 1'b1, 2'd2, 4'b0000};
        tbl[15] = '{5'b00110, 1'b1, 2'd2, 4'b0000};
        tbl[16] = '{5'b00110, 1'b1, 2'd2, 4'b0000};
        tbl[17] = '{5'b00111, 1'b0, 2'd0, 4'b0000};
        tbl[18] = '{5'b00110, 1'b0, 2'd0, 4'b0001};
        tbl[19] = '{5'b00111, 1'b0, 2'd0, 4'b0000};
        tbl[20] = '{5'b00000, 1'b0, 2'd0, 4'b0000};
        tbl[21] = '{5'b11110, 1'b0, 2'd0, 4'b0000};
        tbl[22] = '{5'b11110, 1'b1, 2'd1, 4'b0000};
        tbl[23] = '{5'b00000, 1'b0, 2'd1, 4'b0000};

        // Reset state
        #12;
        chk("rst_s_cyc", {31'h0, s_cyc}, 32'h0);
        chk("rst_s_adr", s_adr, 32'h0);
        chk("rst_flags", {28'h0, m0_ack, m1_ack, m0_err, m1_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Per-cycle vector table
        for (int i = 0; i < 24; i++) begin
            {mcyc[0], mstb[0], mcyc[1], mstb[1], tb_ack} = tbl[i].stim;
            #1;
            case (tbl[i].eadr)
                2'd1:    exp_adr = 32'h100;
                2'd2:    exp_adr = 32'h200;
                default: exp_adr = 32'h0;
            endcase
            chk($sformatf("tbl%0d_s_cyc", i), {31'h0, s_cyc}, {31'h0, tbl[i].ecyc});
            chk($sformatf("tbl%0d_s_stb", i), {31'h0, s_stb}, {31'h0, tbl[i].ecyc});
            chk($sformatf("tbl%0d_s_adr", i), s_adr, exp_adr);
            chk($sformatf("tbl%0d_flags", i), {28'h0, m0_ack, m1_ack, m0_err, m1_err},
                {28'h0, tbl[i].eflg});
            @(negedge clk);
        end

        // Reset during a BUSY transfer of m1 (last grant was m0)
        {mcyc[0], mstb[0], mcyc[1], mstb[1], tb_ack} = 5'b11110;
        @(negedge clk); #1;
        chk("pre_rst_grant_m1", s_adr, 32'h200);
        tb_ack = 1'b1; #1;
        chk("pre_rst_m1_ack", {31'h0, m1_ack}, 32'h1);
        rst_n = 1'b0; #1;
        chk("rst_async_cyc", {31'h0, s_cyc}, 32'h0);
        chk("rst_async_ack", {30'h0, m0_ack, m1_ack}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; tb_ack = 1'b0; #1;
        chk("post_rst_idle", {31'h0, s_cyc}, 32'h0);
        @(negedge clk); #1;
        chk("post_rst_tie_m0", s_adr, 32'h100);
        chk("post_rst_cyc", {31'h0, s_cyc}, 32'h1);
        @(negedge clk);
        {mcyc[0], mstb[0], mcyc[1], mstb[1], tb_ack} = 5'b00000;
        @(negedge clk);
        @(negedge clk);

        // Single write then read-back through the bench slave
        slave_en = 1'b1;
        mwe[0] = 1'b1; madr[0] = 32'h10; mwdat[0] = 32'hDEADBEEF; msel[0] = 4'hF;
        mcyc[0] = 1'b1; mstb[0] = 1'b1; #1;
        chk("wr_arb_cycle", {31'h0, s_cyc}, 32'h0);
        @(negedge clk); #1;
        chk("wr_s_cyc", {31'h0, s_cyc}, 32'h1);
        chk("wr_s_adr", s_adr, 32'h10);
        chk("wr_s_dat", s_wdat, 32'hDEADBEEF);
        chk("wr_s_we_sel", {27'h0, s_we, s_sel}, 32'h1F);
        chk("wr_no_ack_yet", {31'h0, m0_ack}, 32'h0);
        @(negedge clk); #1;
        chk("wr_ack", {31'h0, m0_ack}, 32'h1);
        @(negedge clk);
        mcyc[0] = 1'b0; mstb[0] = 1'b0; mwe[0] = 1'b0; #1;
        chk("wr_ack_single", {31'h0, m0_ack}, 32'h0);
        @(negedge clk);
        beat(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, got);
        chk("rd_ack", {31'h0, got}, 32'h1);
        chk("rd_data", rd, 32'hDEADBEEF);
        mcyc[0] = 1'b0; mstb[0] = 1'b0;
        ref_mem[4] = 32'hDEADBEEF;
        @(negedge clk);

        // Random contention traffic
        rand_lat = 1'b1;
        fork
            master_run(0, 40);
            master_run(1, 40);
            begin
                while (done_cnt < 2) begin
                    @(negedge clk); #1;
                    if (m0_ack | m1_ack | m0_err | m1_err) begin
                        chk("ack_exclusive", {30'h0, m0_ack, m1_ack}, {30'h0, m0_ack & ~m1_ack, m1_ack & ~m0_ack});
                        chk("no_err", {30'h0, m0_err, m1_err}, 32'h0);
                    end
                end
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master to one-slave Wishbone arbiter sitting directly upstream of the on-chip inferred-RAM Wishbone slave.
- Lets the CPU data port (master 0) and a second master (debug/DMA, master 1) share the RAM.
- Uses round-robin grant, holds the grant for the whole cyc, and has a watchdog that returns err if the slave never acks.

Parameters:
- TIMEOUT_CYCLES, 16: cycles with stb high and no ack before an error is returned; 0 disables the watchdog.
- CNT_WIDTH, 8: width of the watchdog counter; must satisfy TIMEOUT_CYCLES < 2^CNT_WIDTH.

Ports:
- wb_clk_i  in  1  single clock, all state on the rising edge.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 request.
- m0_adr_i  in  32  master 0 address.
- m0_dat_i  in  32  master 0 write data.
- m0_sel_i  in  4  master 0 byte selects.
- m0_ack_o  out  1  master 0 acknowledge.
- m0_err_o  out  1  master 0 error.
- m0_dat_o  out  32  master 0 read data.
- m1_*: same set as m0_*, for master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  request to slave.
- s_adr_o  out  32  address to slave.
- s_dat_o  out  32  write data to slave.
- s_sel_o  out  4  byte selects to slave.
- s_ack_i  in  1  slave acknowledge.
- s_dat_i  in  32  slave read data.

Behaviour:
- Reset: wb_clk_i is the only clock. wb_rst_ni is asynchronous, active-low. On reset:
  - state=IDLE, grant=0, last_grant=1 (master 0 wins the first tie), wdog=0.
  - s_cyc_o=s_stb_o=s_we_o=0; s_adr_o, s_dat_o, s_sel_o=0.
  - m0/m1 ack_o=err_o=0.
- Reset asserted mid-transfer: all outputs drop immediately (asynchronous) and no ack/err is delivered. Masters restart their transfers.
- States: IDLE, BUSY, ERR.
- IDLE:
  - Slave outputs are 0.
  - Request = mX_cyc_i & mX_stb_i.
  - One request only: grant that master, go to BUSY.
  - Both requesting: grant = !last_grant, go to BUSY.
  - Arbitration costs exactly 1 cycle; s_cyc_o rises the cycle after the request is seen.
- BUSY:
  - s_cyc/stb/we/adr/dat/sel mirror the granted master combinationally.
  - mX_ack_o = s_ack_i & (grant==X). The non-granted ack and err stay 0.
  - m0_dat_o = m1_dat_o = s_dat_i (broadcast; only meaningful with ack).
- Release and lock:
  - When the granted master's cyc_i=0: last_grant<=grant, go to IDLE. s_cyc_o follows the master combinationally, so it is 0 that same cycle.
  - The grant is held for the full cyc: multi-beat/back-to-back stb under one cyc is never interrupted.
  - A request from the other master during BUSY waits and is served next.
- Watchdog:
  - Active in BUSY while s_stb_o & !s_ack_i: wdog increments each cycle.
  - Cleared on s_ack_i, on granted stb low, and on leaving BUSY.
  - When wdog==TIMEOUT_CYCLES-1 with no ack, next cycle: go to ERR, mX_err_o=1 for exactly 1 cycle for the granted master.
  - TIMEOUT_CYCLES=0 disables the watchdog; it never fires.
- ERR:
  - s_cyc_o=s_stb_o=0 (slave aborted).
  - Stay until the granted master's cyc_i=0, then last_grant<=grant and go to IDLE.
  - A late s_ack_i in ERR is ignored, not forwarded.
- Simultaneous events:
  - Ack on the same cycle the watchdog would fire: the ack wins, no err.
  - Release and a new request from the same master on the same cycle: the master passes through IDLE; round-robin then favours the other master if both request.
- Ack is never asserted on both masters; ack and err are never both high.

Test Plan:
- Single write: m0 writes adr=0x10, dat=0xDEADBEEF, sel=0xF, slave acks 1 cycle after s_stb_o → s_cyc_o rises 1 cycle after the request; m0_ack_o pulses once; a subsequent read of 0x10 returns 0xDEADBEEF on m0_dat_o.
- Tie: m0 and m1 request on the same cycle after reset → m0 is served first; m1 is granted the cycle after m0 drops cyc. Repeat the tie → m1 first (alternation).
- Lock: m0 does 3 back-to-back reads under one cyc while m1 requests → no s_adr_o switch to m1 until m0 drops cyc; m1_ack_o stays 0 throughout.
- Timeout: TIMEOUT_CYCLES=4, slave never acks → m1_err_o high exactly 1 cycle, 5 cycles after s_stb_o rises; s_cyc_o=0 until m1 drops cyc; a late s_ack_i produces no ack.
- Reset mid-transfer: assert wb_rst_ni=0 during a BUSY read → s_cyc_o and all acks drop asynchronously; after release, a tie grants m0.
